// File: rtl/trivium_link_host.sv
// Host-side initiator for the Trivium UART cipher link.
// Sends one plaintext byte as an 8N1 frame (LSB first) and collects the single
// ciphertext byte returned by the core, with a response timeout. The receiver
// runs continuously; bytes outside an outstanding transaction are flagged as stray.
module trivium_link_host #(
   parameter int unsigned CLK_FREQ      = 100000000,
   parameter int unsigned BAUD          = 9600,
   parameter int unsigned TIMEOUT_BYTES = 4
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       req_valid,
   input  logic [7:0] req_data,
   output logic       req_ready,
   output logic       resp_valid,
   output logic [7:0] resp_data,
   output logic       resp_timeout,
   output logic       frame_err,
   output logic       stray,
   output logic       tx,
   input  logic       rx
);

   localparam int unsigned CLKS_PER_BIT = CLK_FREQ / BAUD;
   localparam int unsigned HALF_BIT     = CLKS_PER_BIT / 2;
   localparam int unsigned TIMEOUT_CLKS = TIMEOUT_BYTES * 10 * CLKS_PER_BIT;
   localparam int unsigned CNT_W        = $clog2(TIMEOUT_CLKS + 1);
   localparam int unsigned RCNT_W       = $clog2(CLKS_PER_BIT + 1);

   localparam logic [CNT_W-1:0]  BIT_LAST    = CNT_W'(CLKS_PER_BIT - 1);
   localparam logic [CNT_W-1:0]  TMO_LAST    = CNT_W'(TIMEOUT_CLKS - 1);
   localparam logic [RCNT_W-1:0] R_BIT_LAST  = RCNT_W'(CLKS_PER_BIT - 1);
   localparam logic [RCNT_W-1:0] R_HALF_LAST = RCNT_W'(HALF_BIT - 1);

   // Transmit / transaction FSM
   localparam logic [2:0] S_IDLE      = 3'd0;
   localparam logic [2:0] S_TX_START  = 3'd1;
   localparam logic [2:0] S_TX_DATA   = 3'd2;
   localparam logic [2:0] S_TX_STOP   = 3'd3;
   localparam logic [2:0] S_WAIT_RESP = 3'd4;

   // Receiver FSM
   localparam logic [1:0] R_IDLE  = 2'd0;
   localparam logic [1:0] R_START = 2'd1;
   localparam logic [1:0] R_DATA  = 2'd2;
   localparam logic [1:0] R_STOP  = 2'd3;

   logic [2:0]        state_q, state_d;
   logic [CNT_W-1:0]  cnt_q, cnt_d;
   logic [2:0]        idx_q, idx_d;
   logic [7:0]        data_q, data_d;
   logic              tx_q, tx_d;
   logic              held_q, held_d;
   logic [7:0]        held_data_q, held_data_d;
   logic              resp_valid_q, resp_valid_d;
   logic [7:0]        resp_data_q, resp_data_d;
   logic              resp_timeout_q, resp_timeout_d;
   logic              frame_err_q, frame_err_d;
   logic              stray_q, stray_d;

   logic              rx_meta_q, rx_sync_q, rx_last_q;
   logic [1:0]        rstate_q, rstate_d;
   logic [RCNT_W-1:0] rcnt_q, rcnt_d;
   logic [2:0]        ridx_q, ridx_d;
   logic [7:0]        rshift_q, rshift_d;

   logic              byte_ok;
   logic              accept;
   logic              in_window;

   assign req_ready    = (state_q == S_IDLE) && !rst;
   assign accept       = req_valid && req_ready;
   // The accept cycle itself already belongs to the outstanding window.
   assign in_window    = (state_q != S_IDLE) || accept;

   assign tx           = tx_q;
   assign resp_valid   = resp_valid_q;
   assign resp_data    = resp_data_q;
   assign resp_timeout = resp_timeout_q;
   assign frame_err    = frame_err_q;
   assign stray        = stray_q;

   // Receiver next state: start detect, mid-bit sampling, stop-bit check
   always_comb begin
      rstate_d    = rstate_q;
      rcnt_d      = rcnt_q;
      ridx_d      = ridx_q;
      rshift_d    = rshift_q;
      byte_ok     = 1'b0;
      frame_err_d = 1'b0;
      case (rstate_q)
         R_IDLE: begin
            if (!rx_sync_q && rx_last_q) begin
               rstate_d = R_START;
               rcnt_d   = '0;
            end
         end
         R_START: begin
            if (rcnt_q == R_HALF_LAST) begin
               rcnt_d   = '0;
               ridx_d   = '0;
               // Line back high at mid-start means a glitch, not a frame.
               rstate_d = rx_sync_q ? R_IDLE : R_DATA;
            end else begin
               rcnt_d = rcnt_q + 1'b1;
            end
         end
         R_DATA: begin
            if (rcnt_q == R_BIT_LAST) begin
               rcnt_d   = '0;
               rshift_d = {rx_sync_q, rshift_q[7:1]};
               ridx_d   = ridx_q + 3'd1;
               if (ridx_q == 3'd7) begin
                  rstate_d = R_STOP;
               end
            end else begin
               rcnt_d = rcnt_q + 1'b1;
            end
         end
         R_STOP: begin
            if (rcnt_q == R_BIT_LAST) begin
               rcnt_d   = '0;
               rstate_d = R_IDLE;
               if (rx_sync_q) begin
                  byte_ok = 1'b1;
               end else begin
                  frame_err_d = 1'b1;
               end
            end else begin
               rcnt_d = rcnt_q + 1'b1;
            end
         end
         default: rstate_d = R_IDLE;
      endcase
   end

   // Transaction next state: serialiser, response capture, completion and timeout
   always_comb begin
      state_d        = state_q;
      cnt_d          = cnt_q;
      idx_d          = idx_q;
      data_d         = data_q;
      tx_d           = tx_q;
      held_d         = held_q;
      held_data_d    = held_data_q;
      resp_valid_d   = 1'b0;
      resp_data_d    = resp_data_q;
      resp_timeout_d = 1'b0;
      stray_d        = 1'b0;

      // Only the first good byte of a window is the response.
      if (byte_ok) begin
         if (in_window && !held_q) begin
            held_d      = 1'b1;
            held_data_d = rshift_q;
         end else begin
            stray_d = 1'b1;
         end
      end

      case (state_q)
         S_IDLE: begin
            if (accept) begin
               data_d  = req_data;
               tx_d    = 1'b0;
               cnt_d   = '0;
               state_d = S_TX_START;
            end
         end
         S_TX_START: begin
            if (cnt_q == BIT_LAST) begin
               cnt_d   = '0;
               idx_d   = '0;
               tx_d    = data_q[0];
               state_d = S_TX_DATA;
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
         end
         S_TX_DATA: begin
            if (cnt_q == BIT_LAST) begin
               cnt_d = '0;
               if (idx_q == 3'd7) begin
                  tx_d    = 1'b1;
                  state_d = S_TX_STOP;
               end else begin
                  idx_d = idx_q + 3'd1;
                  tx_d  = data_q[idx_q + 3'd1];
               end
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
         end
         S_TX_STOP: begin
            if (cnt_q == BIT_LAST) begin
               cnt_d   = '0;
               state_d = S_WAIT_RESP;
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
         end
         S_WAIT_RESP: begin
            // A response arriving on the expiry cycle still wins.
            if (held_q || byte_ok) begin
               resp_valid_d = 1'b1;
               resp_data_d  = held_q ? held_data_q : rshift_q;
               held_d       = 1'b0;
               cnt_d        = '0;
               state_d      = S_IDLE;
            end else if (cnt_q == TMO_LAST) begin
               resp_timeout_d = 1'b1;
               cnt_d          = '0;
               state_d        = S_IDLE;
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
         end
         default: state_d = S_IDLE;
      endcase
   end

   // State registers with synchronous reset; rx synchroniser resets to idle-high
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q        <= S_IDLE;
         cnt_q          <= '0;
         idx_q          <= '0;
         data_q         <= '0;
         tx_q           <= 1'b1;
         held_q         <= 1'b0;
         held_data_q    <= '0;
         resp_valid_q   <= 1'b0;
         resp_data_q    <= '0;
         resp_timeout_q <= 1'b0;
         frame_err_q    <= 1'b0;
         stray_q        <= 1'b0;
         rx_meta_q      <= 1'b1;
         rx_sync_q      <= 1'b1;
         rx_last_q      <= 1'b1;
         rstate_q       <= R_IDLE;
         rcnt_q         <= '0;
         ridx_q         <= '0;
         rshift_q       <= '0;
      end else begin
         state_q        <= state_d;
         cnt_q          <= cnt_d;
         idx_q          <= idx_d;
         data_q         <= data_d;
         tx_q           <= tx_d;
         held_q         <= held_d;
         held_data_q    <= held_data_d;
         resp_valid_q   <= resp_valid_d;
         resp_data_q    <= resp_data_d;
         resp_timeout_q <= resp_timeout_d;
         frame_err_q    <= frame_err_d;
         stray_q        <= stray_d;
         rx_meta_q      <= rx;
         rx_sync_q      <= rx_meta_q;
         rx_last_q      <= rx_sync_q;
         rstate_q       <= rstate_d;
         rcnt_q         <= rcnt_d;
         ridx_q         <= ridx_d;
         rshift_q       <= rshift_d;
      end
   end

endmodule

// File: tb/tb_trivium_link_host.sv
// Directed bench for trivium_link_host: 10 clocks per bit, 400-clock timeout.
// A cycle-stepped responder drives rx from a scheduled 10-bit frame.
module tb_trivium_link_host;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       req_valid = 1'b0;
   logic [7:0] req_data = 8'h00;
   logic       req_ready;
   logic       resp_valid;
   logic [7:0] resp_data;
   logic       resp_timeout;
   logic       frame_err;
   logic       stray;
   logic       tx;
   logic       rx = 1'b1;

   int checks = 0;
   int failures = 0;

   int cyc = 0;
   int acc = 0;
   int n_valid = 0, n_tmo = 0, n_ferr = 0, n_stray = 0, n_txlow = 0;
   int last_valid_cyc = -1, last_tmo_cyc = -1, last_ferr_cyc = -1, last_stray_cyc = -1;
   int sched_at = -1;
   int rx_pos = -1;
   int glitch_at = -1;
   int glitch_cnt = 0;
   logic [9:0] sched_frame = 10'h3ff;
   logic [9:0] rx_frame = 10'h3ff;
   logic [9:0] ef;

   trivium_link_host #(
      .CLK_FREQ     (1000000),
      .BAUD         (100000),
      .TIMEOUT_BYTES(4)
   ) dut (
      .clk         (clk),
      .rst         (rst),
      .req_valid   (req_valid),
      .req_data    (req_data),
      .req_ready   (req_ready),
      .resp_valid  (resp_valid),
      .resp_data   (resp_data),
      .resp_timeout(resp_timeout),
      .frame_err   (frame_err),
      .stray       (stray),
      .tx          (tx),
      .rx          (rx)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // One clock: sample outputs 1 time unit after the edge, then update rx.
   task automatic step();
      @(posedge clk);
      #1;
      cyc++;
      if (resp_valid === 1'b1) begin n_valid++; last_valid_cyc = cyc; end
      if (resp_timeout === 1'b1) begin n_tmo++; last_tmo_cyc = cyc; end
      if (frame_err === 1'b1) begin n_ferr++; last_ferr_cyc = cyc; end
      if (stray === 1'b1) begin n_stray++; last_stray_cyc = cyc; end
      if (tx === 1'b0) n_txlow++;
      if (rx_pos >= 0) begin
         rx_pos++;
         if (rx_pos >= 100) begin
            rx = 1'b1;
            rx_pos = -1;
         end else begin
            rx = rx_frame[rx_pos/10];
         end
      end
      if (glitch_cnt > 0) begin
         glitch_cnt--;
         if (glitch_cnt == 0) rx = 1'b1;
      end
      if (cyc == sched_at) begin
         rx_frame = sched_frame;
         rx_pos = 0;
         rx = 1'b0;
         sched_at = -1;
      end
      if (cyc == glitch_at) begin
         rx = 1'b0;
         glitch_cnt = 3;
         glitch_at = -1;
      end
   endtask

   task automatic run(input int n);
      repeat (n) step();
   endtask

   task automatic clear_counts();
      n_valid = 0; n_tmo = 0; n_ferr = 0; n_stray = 0; n_txlow = 0;
      last_valid_cyc = -1; last_tmo_cyc = -1; last_ferr_cyc = -1; last_stray_cyc = -1;
   endtask

   // Offer a byte in IDLE; acc is the cycle right after the accepting edge.
   task automatic accept(input logic [7:0] b);
      clear_counts();
      req_valid = 1'b1;
      req_data = b;
      chk("req_ready_before_accept", req_ready, 1);
      step();
      req_valid = 1'b0;
      acc = cyc;
      chk("tx_low_after_accept", tx, 0);
      chk("req_ready_busy", req_ready, 0);
   endtask

   initial begin
      // Reset state
      run(3);
      chk("rst_tx", tx, 1);
      chk("rst_resp_valid", resp_valid, 0);
      chk("rst_resp_data", resp_data, 0);
      chk("rst_req_ready", req_ready, 0);
      chk("rst_flags", {resp_timeout, frame_err, stray}, 0);
      rst = 1'b0;
      step();
      chk("req_ready_after_rst", req_ready, 1);

      // 1. Basic transaction 0x41 -> 0x1B, with an ignored request mid-frame
      accept(8'h41);
      ef = {1'b1, 8'h41, 1'b0};
      for (int j = 1; j < 100; j++) begin
         req_valid = (j == 30);
         req_data = (j == 30) ? 8'hEE : 8'h41;
         step();
         chk("t1_tx_bit", tx, ef[j/10]);
      end
      req_valid = 1'b0;
      step();
      chk("t1_tx_idle_high", tx, 1);
      chk("t1_no_early_valid", n_valid, 0);
      sched_frame = {1'b1, 8'h41 ^ 8'h5A, 1'b0};
      sched_at = cyc + 1;
      run(99);
      chk("t1_resp_valid", resp_valid, 1);
      chk("t1_resp_data", resp_data, 8'h1B);
      step();
      chk("t1_valid_one_pulse", resp_valid, 0);
      chk("t1_req_ready_after", req_ready, 1);
      run(20);
      chk("t1_valid_count", n_valid, 1);
      chk("t1_no_tmo_stray", n_tmo + n_stray, 0);

      // 2. Timeout with a silent responder
      accept(8'h00);
      run(520);
      chk("t2_tmo_count", n_tmo, 1);
      chk("t2_tmo_time", last_tmo_cyc - acc, 500);
      chk("t2_no_valid", n_valid, 0);
      chk("t2_req_ready", req_ready, 1);

      // 3a. Responder starts its 0xC3 frame during our bit 5
      accept(8'hA5);
      sched_frame = {1'b1, 8'hC3, 1'b0};
      sched_at = acc + 63;
      run(100);
      chk("t3a_no_valid_in_tx", n_valid, 0);
      run(70);
      chk("t3a_valid_count", n_valid, 1);
      chk("t3a_valid_time", last_valid_cyc - acc, 161);
      chk("t3a_resp_data", resp_data, 8'hC3);

      // 3b. Response fully received during TX; released on first WAIT_RESP cycle
      sched_frame = {1'b1, 8'h96, 1'b0};
      sched_at = cyc + 1;
      accept(8'h5A);
      run(100);
      chk("t3b_no_valid_before_wait", n_valid, 0);
      step();
      chk("t3b_resp_valid", resp_valid, 1);
      chk("t3b_resp_data", resp_data, 8'h96);
      sched_frame = {1'b1, 8'h3C, 1'b0};
      sched_at = cyc + 1;
      run(110);
      chk("t3b_stray_count", n_stray, 1);
      chk("t3b_stray_time", last_stray_cyc - acc, 200);
      chk("t3b_valid_count", n_valid, 1);
      chk("t3b_data_held", resp_data, 8'h96);

      // 4. Bad stop bit on the response, then a 3-cycle glitch
      accept(8'h12);
      sched_frame = {1'b0, 8'h34, 1'b0};
      sched_at = acc + 100;
      glitch_at = acc + 250;
      run(520);
      chk("t4_ferr_count", n_ferr, 1);
      chk("t4_ferr_time", last_ferr_cyc - acc, 198);
      chk("t4_tmo_count", n_tmo, 1);
      chk("t4_tmo_time", last_tmo_cyc - acc, 500);
      chk("t4_no_valid_stray", n_valid + n_stray, 0);

      // 5. Reset in the middle of data bit 3 (0xF0 bit 3 is 0)
      accept(8'hF0);
      run(45);
      chk("t5_tx_bit3", tx, 0);
      rst = 1'b1;
      step();
      chk("t5_tx_high", tx, 1);
      chk("t5_resp_data_cleared", resp_data, 0);
      chk("t5_ready_in_rst", req_ready, 0);
      rst = 1'b0;
      step();
      chk("t5_ready_after_rst", req_ready, 1);
      clear_counts();
      run(600);
      chk("t5_no_resp_tmo", n_valid + n_tmo, 0);
      chk("t5_tx_stays_high", n_txlow, 0);

      // 6. Stray byte while idle
      clear_counts();
      sched_frame = {1'b1, 8'hFF, 1'b0};
      sched_at = cyc + 1;
      run(110);
      chk("t6_stray_count", n_stray, 1);
      chk("t6_no_valid", n_valid, 0);
      chk("t6_no_ferr", n_ferr, 0);
      chk("t6_resp_data", resp_data, 0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
